// File: rtl/usb_uart_cmd_parser.sv
// usb_uart_cmd_parser
// Console register-debug port over the USB CDC byte streams. Parses ASCII
// hex commands from the host stream, issues single-byte register-bus
// accesses and returns ASCII responses into the device stream.
//   "W" AA DD <CR|LF>  write DD to register AA   -> "K\r\n"
//   "R" AA <CR|LF>     read register AA          -> "HH\r\n"
//   malformed line or bus timeout                -> "E\r\n"
// Ports:
//   clk_48mhz, reset          clock (USB core domain), async active-high reset
//   rx_data/rx_valid/rx_ready host-to-device byte stream (uart_out_*)
//   tx_data/tx_valid/tx_ready device-to-host byte stream (uart_in_*)
//   bus_addr/bus_wdata        register address / write data
//   bus_we/bus_re             one-cycle write / read strobes
//   bus_rdata/bus_ack         read data, access complete
module usb_uart_cmd_parser #(
  parameter int unsigned BUS_TIMEOUT = 255
) (
  input  logic       clk_48mhz,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [7:0] bus_addr,
  output logic [7:0] bus_wdata,
  output logic       bus_we,
  output logic       bus_re,
  input  logic [7:0] bus_rdata,
  input  logic       bus_ack
);

  typedef enum logic [3:0] {
    IDLE, ADDR_HI, ADDR_LO, DATA_HI, DATA_LO, TERM, DISCARD, BUS, RESP
  } state_t;

  typedef enum logic [1:0] {LD_NONE, LD_ERR, LD_OK, LD_RD} load_t;

  localparam logic [15:0] TMO_LAST = 16'(BUS_TIMEOUT - 1);

  state_t      state, state_n;
  load_t       load;
  logic        op_write;
  logic [15:0] tcnt;
  logic [7:0]  resp_buf [4];
  logic [2:0]  resp_len;
  logic [1:0]  resp_idx;

  logic       rx_fire, tx_fire, last_byte;
  logic       is_term, is_w, is_r, is_hex;
  logic [3:0] nib;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  assign rx_fire   = rx_valid && rx_ready;
  assign tx_fire   = tx_valid && tx_ready;
  assign last_byte = ({1'b0, resp_idx} == (resp_len - 3'd1));
  assign tx_data   = resp_buf[resp_idx];

  assign is_term = (rx_data == 8'h0D) || (rx_data == 8'h0A);
  assign is_w    = (rx_data == 8'h57) || (rx_data == 8'h77);
  assign is_r    = (rx_data == 8'h52) || (rx_data == 8'h72);

  always_comb begin
    is_hex = 1'b1;
    nib    = '0;
    if (rx_data >= 8'h30 && rx_data <= 8'h39) begin
      nib = rx_data[3:0];
    end else if ((rx_data >= 8'h41 && rx_data <= 8'h46) ||
                 (rx_data >= 8'h61 && rx_data <= 8'h66)) begin
      nib = rx_data[3:0] + 4'd9;
    end else begin
      is_hex = 1'b0;
    end
  end

  // Next-state and response-load selection
  always_comb begin
    state_n = state;
    load    = LD_NONE;
    unique case (state)
      IDLE: begin
        if (rx_fire) begin
          if (is_w || is_r) state_n = ADDR_HI;
          else if (!is_term) state_n = DISCARD;
        end
      end
      ADDR_HI, ADDR_LO, DATA_HI, DATA_LO: begin
        if (rx_fire) begin
          if (is_hex) begin
            unique case (state)
              ADDR_HI: state_n = ADDR_LO;
              ADDR_LO: state_n = op_write ? DATA_HI : TERM;
              DATA_HI: state_n = DATA_LO;
              default: state_n = TERM;
            endcase
          end else if (is_term) begin
            load    = LD_ERR;
            state_n = RESP;
          end else begin
            state_n = DISCARD;
          end
        end
      end
      TERM: begin
        if (rx_fire) state_n = is_term ? BUS : DISCARD;
      end
      DISCARD: begin
        if (rx_fire && is_term) begin
          load    = LD_ERR;
          state_n = RESP;
        end
      end
      BUS: begin
        if (bus_ack) begin
          load    = op_write ? LD_OK : LD_RD;
          state_n = RESP;
        end else if (tcnt == TMO_LAST) begin
          load    = LD_ERR;
          state_n = RESP;
        end
      end
      RESP: begin
        if (tx_fire && last_byte) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_48mhz or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      rx_ready  <= 1'b0;
      tx_valid  <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_we    <= 1'b0;
      bus_re    <= 1'b0;
      op_write  <= 1'b0;
      tcnt      <= '0;
      resp_len  <= '0;
      resp_idx  <= '0;
      for (int unsigned i = 0; i < 4; i++) resp_buf[i] <= '0;
    end else begin
      state <= state_n;
      // rx_ready is registered from the next state so it matches the
      // receiving states cycle-for-cycle while staying 0 through reset.
      rx_ready <= !(state_n inside {BUS, RESP});
      bus_we   <= 1'b0;
      bus_re   <= 1'b0;

      if (rx_fire) begin
        unique case (state)
          IDLE:    if (is_w || is_r) op_write <= is_w;
          ADDR_HI: if (is_hex) bus_addr[7:4]  <= nib;
          ADDR_LO: if (is_hex) bus_addr[3:0]  <= nib;
          DATA_HI: if (is_hex) bus_wdata[7:4] <= nib;
          DATA_LO: if (is_hex) bus_wdata[3:0] <= nib;
          default: ;
        endcase
      end

      // Strobe lands on the first BUS cycle; tcnt counts BUS cycles seen.
      if (state == TERM && state_n == BUS) begin
        bus_we <= op_write;
        bus_re <= !op_write;
        tcnt   <= '0;
      end else if (state == BUS) begin
        tcnt <= tcnt + 16'd1;
      end

      if (load != LD_NONE) begin
        tx_valid <= 1'b1;
        resp_idx <= '0;
        unique case (load)
          LD_RD: begin
            resp_buf[0] <= hex_char(bus_rdata[7:4]);
            resp_buf[1] <= hex_char(bus_rdata[3:0]);
            resp_buf[2] <= 8'h0D;
            resp_buf[3] <= 8'h0A;
            resp_len    <= 3'd4;
          end
          default: begin
            resp_buf[0] <= (load == LD_OK) ? 8'h4B : 8'h45;
            resp_buf[1] <= 8'h0D;
            resp_buf[2] <= 8'h0A;
            resp_buf[3] <= 8'h00;
            resp_len    <= 3'd3;
          end
        endcase
      end else if (tx_fire) begin
        if (last_byte) begin
          tx_valid <= 1'b0;
          resp_idx <= '0;
        end else begin
          resp_idx <= resp_idx + 2'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_usb_uart_cmd_parser.sv
module tb_usb_uart_cmd_parser;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] bus_addr, bus_wdata;
  logic       bus_we, bus_re;
  logic [7:0] bus_rdata = 8'h00;
  logic       bus_ack = 1'b0;

  always #5 clk = ~clk;

  usb_uart_cmd_parser #(.BUS_TIMEOUT(4)) dut (
    .clk_48mhz (clk),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_we    (bus_we),
    .bus_re    (bus_re),
    .bus_rdata (bus_rdata),
    .bus_ack   (bus_ack)
  );

  typedef struct {
    string      cmd;
    logic [7:0] rdata;
    int         dly;     // ack delay after strobe; -1 = never
    bit         bp;      // toggle tx_ready
    string      resp;
    bit         has_bus;
    bit         we;
    logic [7:0] addr;
    logic [7:0] wdata;
  } vec_t;

  typedef struct {
    bit         we;
    logic [7:0] addr;
    logic [7:0] wdata;
  } bus_t;

  logic [7:0] resp_q[$];
  bus_t       bus_q[$];

  int total = 0;
  int bad   = 0;
  int cur_dly = -1;
  int ack_cnt = 0;
  bit cur_bp = 1'b0;
  bit mon_en = 1'b1;
  logic mon_ready = 1'b0;
  logic man_ready = 1'b0;

  assign tx_ready = mon_en ? mon_ready : man_ready;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Bus responder and strobe checker
  always @(negedge clk) begin
    bus_t e;
    bus_ack = 1'b0;
    if (ack_cnt > 0) begin
      ack_cnt--;
      if (ack_cnt == 0) bus_ack = 1'b1;
    end
    if (bus_we || bus_re) begin
      if (bus_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL bus_unexp: got we=%0b re=%0b addr=%02h want no strobe", bus_we, bus_re, bus_addr);
      end else begin
        e = bus_q.pop_front();
        check("bus_we", 32'(bus_we), 32'(e.we));
        check("bus_re", 32'(bus_re), 32'(!e.we));
        check("bus_addr", 32'(bus_addr), 32'(e.addr));
        if (e.we) check("bus_wdata", 32'(bus_wdata), 32'(e.wdata));
      end
      if (cur_dly == 0) bus_ack = 1'b1;
      else if (cur_dly > 0) ack_cnt = cur_dly;
    end
  end

  // Response sink: decides tx_ready for the coming edge and scores the byte
  always @(negedge clk) begin
    if (mon_en) begin
      mon_ready = cur_bp ? ~mon_ready : 1'b1;
      if (tx_valid) check("rx_ready_in_resp", 32'(rx_ready), 32'd0);
      if (tx_valid && mon_ready) begin
        if (resp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL tx_unexp: got %02h want none", tx_data);
        end else begin
          check("tx_byte", 32'(tx_data), 32'(resp_q.pop_front()));
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      total++;
      bad++;
      $display("FAIL rx_accept: got timeout want byte %02h accepted", b);
    end else begin
      @(posedge clk);
      #1;
    end
    rx_valid = 1'b0;
  endtask

  task automatic send_line(input string s);
    for (int k = 0; k < s.len(); k++) send_byte(s[k]);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((resp_q.size() != 0 || bus_q.size() != 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(n < 500), 32'd1);
    repeat (12) @(negedge clk);
  endtask

  initial begin
    vec_t v[13];
    int   n;

    v[0]  = '{"W3A5C\015\012", 8'h00,  1, 1'b0, "K\015\012",  1'b1, 1'b1, 8'h3A, 8'h5C};
    v[1]  = '{"r0f\012",       8'hB7,  3, 1'b1, "B7\015\012", 1'b1, 1'b0, 8'h0F, 8'h00};
    v[2]  = '{"W1G22\015",     8'h00, -1, 1'b0, "E\015\012",  1'b0, 1'b0, 8'h00, 8'h00};
    v[3]  = '{"R01\015",       8'h4E,  0, 1'b0, "4E\015\012", 1'b1, 1'b0, 8'h01, 8'h00};
    v[4]  = '{"R1\015",        8'h00, -1, 1'b0, "E\015\012",  1'b0, 1'b0, 8'h00, 8'h00};
    v[5]  = '{"R10\015",       8'h99,  8, 1'b0, "E\015\012",  1'b1, 1'b0, 8'h10, 8'h00};
    v[6]  = '{"wab0c\012",     8'h00,  2, 1'b1, "K\015\012",  1'b1, 1'b1, 8'hAB, 8'h0C};
    v[7]  = '{"Rff\015",       8'h0A,  3, 1'b0, "0A\015\012", 1'b1, 1'b0, 8'hFF, 8'h00};
    v[8]  = '{"\015\012",      8'h00, -1, 1'b0, "",           1'b0, 1'b0, 8'h00, 8'h00};
    v[9]  = '{"X12\015",       8'h00, -1, 1'b0, "E\015\012",  1'b0, 1'b0, 8'h00, 8'h00};
    v[10] = '{"R123\015",      8'h00, -1, 1'b0, "E\015\012",  1'b0, 1'b0, 8'h00, 8'h00};
    v[11] = '{"W12\015",       8'h00, -1, 1'b0, "E\015\012",  1'b0, 1'b0, 8'h00, 8'h00};
    v[12] = '{"R10\015",       8'h55,  4, 1'b0, "E\015\012",  1'b1, 1'b0, 8'h10, 8'h00};

    repeat (3) @(negedge clk);
    check("rst_rx_ready", 32'(rx_ready), 32'd0);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_bus_addr", 32'(bus_addr), 32'd0);
    check("rst_bus_wdata", 32'(bus_wdata), 32'd0);
    check("rst_bus_we", 32'(bus_we), 32'd0);
    check("rst_bus_re", 32'(bus_re), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_rx_ready", 32'(rx_ready), 32'd1);

    for (int i = 0; i < 13; i++) begin
      cur_dly   = v[i].dly;
      cur_bp    = v[i].bp;
      bus_rdata = v[i].rdata;
      for (int k = 0; k < v[i].resp.len(); k++) resp_q.push_back(v[i].resp[k]);
      if (v[i].has_bus) bus_q.push_back('{v[i].we, v[i].addr, v[i].wdata});
      send_line(v[i].cmd);
      wait_done();
    end

    // Reset while the read response is partway out
    man_ready = 1'b0;
    mon_en    = 1'b0;
    cur_bp    = 1'b0;
    cur_dly   = 3;
    bus_rdata = 8'hB7;
    bus_q.push_back('{1'b0, 8'h0F, 8'h00});
    send_line("r0f\012");
    n = 0;
    while (!tx_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("mid_tx_valid", 32'(tx_valid), 32'd1);
    check("mid_byte0", 32'(tx_data), 32'h42);
    man_ready = 1'b1;
    @(posedge clk);
    #1;
    man_ready = 1'b0;
    check("mid_byte1", 32'(tx_data), 32'h37);
    check("mid_held", 32'(tx_valid), 32'd1);
    reset = 1'b1;
    #1;
    check("async_tx_valid", 32'(tx_valid), 32'd0);
    check("async_rx_ready", 32'(rx_ready), 32'd0);
    check("async_tx_data", 32'(tx_data), 32'd0);
    repeat (2) @(negedge clk);
    reset  = 1'b0;
    mon_en = 1'b1;
    cur_dly = -1;
    resp_q.push_back(8'h45);
    resp_q.push_back(8'h0D);
    resp_q.push_back(8'h0A);
    send_line("W000\012");
    wait_done();

    check("resp_q_empty", 32'(resp_q.size()), 32'd0);
    check("bus_q_empty", 32'(bus_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/usb_uart_cmd_parser.md
Name: usb_uart_cmd_parser

Overview:
- Downstream/upstream neighbour of the USB CDC UART core. Consumes the host-to-device byte stream (uart_out_*), parses ASCII hex register commands, and performs single-byte register-bus reads and writes.
- Returns ASCII responses into the device-to-host stream (uart_in_*).
- Gives the host a console-driven register debug port over USB serial.

Parameters:
- BUS_TIMEOUT, 255: cycles to wait for bus_ack after the strobe before aborting with an error; range 1..65535.

Ports:
- clk_48mhz  input  1  system clock, same domain as the USB core.
- reset  input  1  asynchronous, active-high reset.
- rx_data  input  8  host byte; connects to uart_out_data.
- rx_valid  input  1  rx_data valid; connects to uart_out_valid.
- rx_ready  output  1  byte accepted when rx_valid && rx_ready; connects to uart_out_ready.
- tx_data  output  8  response byte; connects to uart_in_data.
- tx_valid  output  1  tx_data valid; connects to uart_in_valid.
- tx_ready  input  1  sink accepts when tx_valid && tx_ready; connects to uart_in_ready.
- bus_addr  output  8  register address.
- bus_wdata  output  8  write data.
- bus_we  output  1  one-cycle write strobe.
- bus_re  output  1  one-cycle read strobe.
- bus_rdata  input  8  read data; sampled on the bus_ack cycle.
- bus_ack  input  1  access complete.

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0 (rx_ready, tx_valid, tx_data, bus_addr, bus_wdata, bus_we, bus_re); response buffer cleared; timeout counter 0.
- Grammar, one command per line; terminator is CR (0x0D) or LF (0x0A):
  - "W" AA DD term: write.
  - "R" AA term: read.
  - 'W'/'R' and hex digits are case-insensitive. No spaces allowed.
- Hex decode: '0'-'9' -> 0-9, 'A'-'F'/'a'-'f' -> 10-15. Any other character is not a hex digit.
- rx_ready = 1 in IDLE, ADDR_HI, ADDR_LO, DATA_HI, DATA_LO, TERM and DISCARD; 0 in BUS and RESP. Exactly one byte is consumed per handshake cycle.
- State transitions, each on an accepted byte:
  - IDLE: 'W'/'w' -> ADDR_HI (op=write). 'R'/'r' -> ADDR_HI (op=read). Terminator -> stay IDLE, no response (blank lines and the LF of CRLF are ignored). Other -> DISCARD.
  - ADDR_HI: hex -> bus_addr[7:4], go ADDR_LO. Else error.
  - ADDR_LO: hex -> bus_addr[3:0]; go DATA_HI if write, TERM if read. Else error.
  - DATA_HI / DATA_LO: hex -> bus_wdata[7:4] / [3:0]; DATA_LO then goes to TERM. Else error.
  - TERM: terminator -> BUS. Any other byte -> DISCARD.
  - Error rule: a terminator received where a hex digit is expected -> load "E\r\n", go RESP. A non-hex, non-terminator byte -> DISCARD.
  - DISCARD: swallow bytes until a terminator, then load "E\r\n" and go RESP.
- BUS state:
  - The first cycle asserts bus_we (write) or bus_re (read) for exactly one cycle. bus_addr and bus_wdata are stable from that cycle until the next command.
  - bus_ack is honoured from the strobe cycle onward.
  - Write ack -> load "K\r\n". Read ack -> load two uppercase hex chars of bus_rdata, then "\r\n" (4 bytes).
  - If no ack has arrived after BUS_TIMEOUT cycles -> load "E\r\n". An ack arriving after the timeout is ignored.
- RESP state:
  - tx_valid = 1 with tx_data set to the current buffer byte. Both are held stable until tx_ready.
  - Each handshake advances the byte; after the last byte, tx_valid drops the next cycle and the state returns to IDLE.
  - Back-pressure (tx_ready=0) may be indefinite. No input is accepted during RESP.
- Responses are strictly one per terminated non-blank line. Commands never overlap.
- Reset asserted mid-command or mid-response: the partial command or response is abandoned and never resumed.

Test Plan:
- Write with response: send "W3A5C\r\n", bus_ack on the cycle after the strobe -> bus_we pulses once with addr 0x3A and wdata 0x5C; tx emits 'K',0x0D,0x0A; the LF is ignored silently; state returns to IDLE.
- Read with back-pressure: send "r0f\n", bus_rdata=0xB7 with ack 3 cycles after bus_re; tx_ready toggled 1/0 -> bus_re pulses once with addr 0x0F; tx emits "B7\r\n" in order with no duplicates or drops; rx_ready=0 throughout RESP.
- Parse error: send "W1G22\r" -> no bus strobe; tx emits "E\r\n" only after the CR; the following "R01\r" executes normally.
- Bus timeout: BUS_TIMEOUT=4, send "R10\r", bus_ack never asserted -> bus_re pulses once; "E\r\n" is emitted after 4 cycles; a late ack is ignored.
- Short command: send "R1\r" -> tx emits "E\r\n"; no bus strobe.
- Reset mid-response: assert reset after the first byte of "B7\r\n" is accepted -> tx_valid=0 immediately; after release, a new "W000\n" fails (3 digits) with "E\r\n".
